// File: rtl/mips_cpu_hilo_pkg.sv
// Shared HI/LO unit definitions: operation codes, FSM states and divide length.
// Also imported by the execute-stage decoder.
package mips_cpu_hilo_pkg;
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_DIV  = 3'd1,
        OP_DIVU = 3'd2,
        OP_MTHI = 3'd3,
        OP_MTLO = 3'd4
    } hilo_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREP,
        ST_RUN,
        ST_FIX
    } hilo_state_t;

    localparam int DIV_ITERS = 32;
endpackage

// File: rtl/mips_cpu_divcore.sv
// Unsigned 32-bit restoring divider, one quotient bit per cycle.
// The first iteration happens on the start edge, using the input operands directly.
module mips_cpu_divcore #(
    parameter int ITERS = mips_cpu_hilo_pkg::DIV_ITERS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] q,
    output logic [31:0] r,
    output logic        done
);
    logic [31:0] acc_q, quo_q, dvs_q;
    logic [31:0] acc_d, quo_d;
    logic [31:0] acc_in, quo_in, dvs_in;
    logic [32:0] acc_sh, diff;
    logic [5:0]  cnt_q;
    logic        run_q, done_q;

    // Remainder is always below the divisor, so a 33-bit trial subtract
    // borrows (bit 32 set) exactly when the shifted accumulator is too small.
    always_comb begin
        acc_in = start ? 32'd0    : acc_q;
        quo_in = start ? dividend : quo_q;
        dvs_in = start ? divisor  : dvs_q;
        acc_sh = {acc_in, quo_in[31]};
        diff   = acc_sh - {1'b0, dvs_in};
        acc_d  = diff[32] ? acc_sh[31:0] : diff[31:0];
        quo_d  = {quo_in[30:0], ~diff[32]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                acc_q <= acc_d;
                quo_q <= quo_d;
                dvs_q <= divisor;
                cnt_q <= 6'd1;
                run_q <= 1'b1;
            end else if (run_q) begin
                acc_q <= acc_d;
                quo_q <= quo_d;
                cnt_q <= cnt_q + 6'd1;
                if (cnt_q == 6'(ITERS - 1)) begin
                    run_q  <= 1'b0;
                    cnt_q  <= '0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign q    = quo_q;
    assign r    = acc_q;
    assign done = done_q;
endmodule

// File: rtl/mips_cpu_hilo_div.sv
// HI/LO register unit: MTHI/MTLO writes and iterative DIV/DIVU with sign fix-up.
// busy is a registered copy of (state != IDLE); the CPU stalls on it.
module mips_cpu_hilo_div #(
    parameter int DIV_ITERS = mips_cpu_hilo_pkg::DIV_ITERS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        dbz
);
    import mips_cpu_hilo_pkg::*;

    hilo_state_t state_q;
    logic [31:0] hi_q, lo_q, a_q, b_q;
    logic        busy_q, dbz_q, sgn_q, q_neg_q, r_neg_q;
    logic [31:0] mag_a, mag_b, core_q, core_r;
    logic        core_start, core_done;

    assign mag_a      = (sgn_q && a_q[31]) ? -a_q : a_q;
    assign mag_b      = (sgn_q && b_q[31]) ? -b_q : b_q;
    assign core_start = (state_q == ST_PREP) && (b_q != 32'd0);

    mips_cpu_divcore #(.ITERS(DIV_ITERS)) u_core (
        .clk      (clk),
        .reset    (reset),
        .start    (core_start),
        .dividend (mag_a),
        .divisor  (mag_b),
        .q        (core_q),
        .r        (core_r),
        .done     (core_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            dbz_q   <= 1'b0;
            sgn_q   <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            dbz_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (op_valid) begin
                    case (hilo_op_t'(op))
                        OP_MTHI: hi_q <= rs_data;
                        OP_MTLO: lo_q <= rs_data;
                        OP_DIV, OP_DIVU: begin
                            a_q     <= rs_data;
                            b_q     <= rt_data;
                            sgn_q   <= (hilo_op_t'(op) == OP_DIV);
                            state_q <= ST_PREP;
                            busy_q  <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_PREP: begin
                    if (b_q == 32'd0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        dbz_q   <= 1'b1;
                    end else begin
                        q_neg_q <= sgn_q & (a_q[31] ^ b_q[31]);
                        r_neg_q <= sgn_q & a_q[31];
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: if (core_done) state_q <= ST_FIX;
                ST_FIX: begin
                    lo_q    <= q_neg_q ? -core_q : core_q;
                    hi_q    <= r_neg_q ? -core_r : core_r;
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign dbz  = dbz_q;
endmodule

// File: tb/tb_mips_cpu_hilo_div.sv
// Self-checking bench for the HI/LO divide unit: directed cases plus random ops
// compared against a 64-bit arithmetic reference model.
module tb_mips_cpu_hilo_div;
    logic        clk = 1'b0;
    logic        reset, op_valid;
    logic [2:0]  op;
    logic [31:0] rs_data, rt_data, hi, lo;
    logic        busy, dbz;
    int          checks = 0, failures = 0;
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    mips_cpu_hilo_div dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .busy(busy), .hi(hi), .lo(lo), .dbz(dbz)
    );

    // Reference: truncating division done in 64-bit arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int exp_dz, output int exp_bc);
        longint sa, sb, qq, rr;
        exp_dz = 0; exp_bc = 0;
        case (o)
            3'd1, 3'd2: begin
                if (b == 32'd0) begin
                    exp_dz = 1; exp_bc = 1;
                end else begin
                    if (o == 3'd1) begin
                        sa = longint'($signed(a)); sb = longint'($signed(b));
                    end else begin
                        sa = longint'({32'd0, a}); sb = longint'({32'd0, b});
                    end
                    qq = sa / sb; rr = sa % sb;
                    m_lo = qq[31:0]; m_hi = rr[31:0];
                    exp_bc = 34;
                end
            end
            3'd3: m_hi = a;
            3'd4: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one request from an idle unit, then follow busy until it drops.
    task automatic drive_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            output int bc, output int dz);
        op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
        @(posedge clk); #1;
        op_valid = 1'b0; op = 3'd0;
        bc = 0; dz = 0;
        while (busy && bc < 100) begin
            bc++;
            @(posedge clk); #1;
            if (dbz) dz++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; op_valid = 1'b0; op = 3'd0; rs_data = '0; rt_data = '0;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        m_hi = 0; m_lo = 0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (dbz !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", dbz); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    endtask

    task automatic test_divu_basic();
        int bc, dz, ed, eb;
        model(3'd2, 32'd100, 32'd7, ed, eb);
        drive_op(3'd2, 32'd100, 32'd7, bc, dz);
        checks++; if (bc !== 34) begin failures++; $display("FAIL divu_busy_cycles got=%0d exp=34", bc); end
        checks++; if (dz !== 0) begin failures++; $display("FAIL divu_dbz got=%0d exp=0", dz); end
        checks++; if (lo !== 32'd14) begin failures++; $display("FAIL divu_lo got=%h exp=%h", lo, 32'd14); end
        checks++; if (hi !== 32'd2) begin failures++; $display("FAIL divu_hi got=%h exp=%h", hi, 32'd2); end
    endtask

    task automatic test_div_signed();
        int bc, dz, ed, eb;
        model(3'd1, 32'hFFFFFFF9, 32'd2, ed, eb);
        drive_op(3'd1, 32'hFFFFFFF9, 32'd2, bc, dz);
        checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_m7_2_lo got=%h exp=fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_m7_2_hi got=%h exp=ffffffff", hi); end
        model(3'd1, 32'd7, 32'hFFFFFFFE, ed, eb);
        drive_op(3'd1, 32'd7, 32'hFFFFFFFE, bc, dz);
        checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_7_m2_lo got=%h exp=fffffffd", lo); end
        checks++; if (hi !== 32'd1) begin failures++; $display("FAIL div_7_m2_hi got=%h exp=1", hi); end
    endtask

    task automatic test_boundary();
        int bc, dz, ed, eb;
        model(3'd1, 32'h80000000, 32'hFFFFFFFF, ed, eb);
        drive_op(3'd1, 32'h80000000, 32'hFFFFFFFF, bc, dz);
        checks++; if (lo !== 32'h80000000) begin failures++; $display("FAIL div_min_m1_lo got=%h exp=80000000", lo); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL div_min_m1_hi got=%h exp=0", hi); end
        checks++; if (dz !== 0) begin failures++; $display("FAIL div_min_m1_dbz got=%0d exp=0", dz); end
        model(3'd2, 32'hFFFFFFFF, 32'h80000000, ed, eb);
        drive_op(3'd2, 32'hFFFFFFFF, 32'h80000000, bc, dz);
        checks++; if (lo !== 32'd1) begin failures++; $display("FAIL divu_big_lo got=%h exp=1", lo); end
        checks++; if (hi !== 32'h7FFFFFFF) begin failures++; $display("FAIL divu_big_hi got=%h exp=7fffffff", hi); end
    endtask

    task automatic test_mt_dbz();
        int bc, dz, ed, eb;
        model(3'd3, 32'hAAAA5555, 32'd0, ed, eb);
        drive_op(3'd3, 32'hAAAA5555, 32'd0, bc, dz);
        checks++; if (hi !== 32'hAAAA5555) begin failures++; $display("FAIL mthi got=%h exp=aaaa5555", hi); end
        checks++; if (bc !== 0) begin failures++; $display("FAIL mthi_busy got=%0d exp=0", bc); end
        model(3'd4, 32'h1234, 32'd0, ed, eb);
        drive_op(3'd4, 32'h1234, 32'd0, bc, dz);
        checks++; if (lo !== 32'h1234) begin failures++; $display("FAIL mtlo got=%h exp=1234", lo); end
        model(3'd2, 32'd5, 32'd0, ed, eb);
        drive_op(3'd2, 32'd5, 32'd0, bc, dz);
        checks++; if (bc !== 1) begin failures++; $display("FAIL dbz_busy_cycles got=%0d exp=1", bc); end
        checks++; if (dbz !== 1'b1) begin failures++; $display("FAIL dbz_pulse got=%b exp=1", dbz); end
        @(posedge clk); #1;
        checks++; if (dbz !== 1'b0) begin failures++; $display("FAIL dbz_pulse_end got=%b exp=0", dbz); end
        checks++; if (hi !== 32'hAAAA5555 || lo !== 32'h1234)
            begin failures++; $display("FAIL dbz_hilo got=%h/%h exp=aaaa5555/00001234", hi, lo); end
    endtask

    task automatic test_busy_ignore();
        int bc, ed, eb;
        model(3'd2, 32'd1000, 32'd3, ed, eb);
        op_valid = 1'b1; op = 3'd2; rs_data = 32'd1000; rt_data = 32'd3;
        @(posedge clk); #1;
        op_valid = 1'b0;
        bc = 0;
        while (busy && bc < 100) begin
            bc++;
            if (bc == 5) begin op_valid = 1'b1; op = 3'd4; rs_data = 32'hDEAD; end
            else op_valid = 1'b0;
            @(posedge clk); #1;
        end
        op_valid = 1'b0; op = 3'd0;
        checks++; if (bc !== 34) begin failures++; $display("FAIL ignore_busy_cycles got=%0d exp=34", bc); end
        checks++; if (lo !== 32'd333) begin failures++; $display("FAIL ignore_lo got=%h exp=%h", lo, 32'd333); end
        checks++; if (hi !== 32'd1) begin failures++; $display("FAIL ignore_hi got=%h exp=1", hi); end
    endtask

    task automatic test_reset_mid_run();
        int bc, dz, ed, eb;
        op_valid = 1'b1; op = 3'd1; rs_data = $urandom; rt_data = $urandom_range(1, 1000);
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        m_hi = 0; m_lo = 0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0)
            begin failures++; $display("FAIL midreset_hilo got=%h/%h exp=0/0", hi, lo); end
        model(3'd2, 32'd9, 32'd3, ed, eb);
        drive_op(3'd2, 32'd9, 32'd3, bc, dz);
        checks++; if (bc !== 34) begin failures++; $display("FAIL postreset_busy got=%0d exp=34", bc); end
        checks++; if (lo !== 32'd3 || hi !== 32'd0)
            begin failures++; $display("FAIL postreset_hilo got=%h/%h exp=0/3", hi, lo); end
    endtask

    task automatic test_back_to_back();
        int bc, dz, ed, eb;
        model(3'd1, 32'hFFFFFF00, 32'd17, ed, eb);
        drive_op(3'd1, 32'hFFFFFF00, 32'd17, bc, dz);
        model(3'd3, 32'h0BADF00D, 32'd0, ed, eb);
        drive_op(3'd3, 32'h0BADF00D, 32'd0, bc, dz);
        checks++; if (hi !== m_hi || lo !== m_lo)
            begin failures++; $display("FAIL b2b_hilo got=%h/%h exp=%h/%h", hi, lo, m_hi, m_lo); end
    endtask

    task automatic test_random();
        int bc, dz, ed, eb;
        logic [2:0] o;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) o = 3'($urandom_range(1, 2));
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: b = 32'hFFFFFFFF;
                3: b = {1'b1, 31'($urandom)};
                default: b = $urandom;
            endcase
            model(o, a, b, ed, eb);
            drive_op(o, a, b, bc, dz);
            checks++; if (bc !== eb) begin failures++; $display("FAIL rand%0d_busy op=%0d got=%0d exp=%0d", i, o, bc, eb); end
            checks++; if (dz !== ed) begin failures++; $display("FAIL rand%0d_dbz op=%0d got=%0d exp=%0d", i, o, dz, ed); end
            checks++; if (hi !== m_hi || lo !== m_lo)
                begin failures++; $display("FAIL rand%0d_hilo op=%0d a=%h b=%h got=%h/%h exp=%h/%h", i, o, a, b, hi, lo, m_hi, m_lo); end
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_div_signed();
        test_boundary();
        test_mt_dbz();
        test_busy_ignore();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mips_cpu_hilo_div.md
# mips_cpu_hilo_div

HI/LO register unit for the MIPS CPU, sitting between the execute stage and the iterative divide datapath. It accepts DIV, DIVU, MTHI and MTLO operations from execute. Divides are performed as an unsigned 32-iteration restoring division on operand magnitudes, and the result signs are corrected for DIV. It owns the architectural HI/LO registers read by MFHI/MFLO and holds `busy` high so the CPU stalls until a divide commits.

## Interface
Parameters:
- `DIV_ITERS`, default 32: restoring-division iterations; fixed at 32 for 32-bit operands.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `op_valid`  in  1  operation request; sampled only when `busy`=0.
- `op`  in  3  `hilo_op_t`: NONE=0, DIV=1, DIVU=2, MTHI=3, MTLO=4; other codes are treated as NONE.
- `rs_data`  in  32  dividend, or the MTHI/MTLO source value.
- `rt_data`  in  32  divisor.
- `busy`  out  1  divide in progress; the CPU must stall when it is high.
- `hi`  out  32  architectural HI (remainder).
- `lo`  out  32  architectural LO (quotient).
- `dbz`  out  1  one-cycle pulse when a divide by zero is detected.

## Operation
- States: IDLE, PREP, RUN, FIX.
- **IDLE**, with `op_valid`=1:
  - MTHI: `hi`<=`rs_data`.
  - MTLO: `lo`<=`rs_data`.
  - Both stay in IDLE; `busy` remains 0.
  - DIV/DIVU: latch `rs_data`, `rt_data` and a signed flag, then go to PREP.
- **PREP**:
  - Divisor == 0: go to IDLE, pulse `dbz`, leave HI/LO unchanged.
  - Otherwise compute magnitudes. For DIV, take the 32-bit two's-complement negation of any negative operand. For DIVU, pass operands through.
  - Record `q_neg` = signed & (sign(rs) ^ sign(rt)) and `r_neg` = signed & sign(rs).
  - Start the core and go to RUN.
- **RUN**:
  - One restoring step per cycle: {acc,q} shift left; if acc ≥ divisor, subtract and set the quotient bit.
  - The 6-bit counter runs 0..31; at 31, go to FIX.
  - The accumulator is 33 bits, so the compare cannot overflow for divisors ≥ 2^31.
- **FIX**:
  - `lo`<= `q_neg` ? −q : q.
  - `hi`<= `r_neg` ? −r : r.
  - Go to IDLE.
- Semantics: truncation toward zero; the remainder sign follows the dividend.
- DIV 0x80000000 / 0xFFFFFFFF: magnitudes give q=0x80000000, and negation wraps, so LO=0x80000000, HI=0. No flag is raised.
- Any `op_valid` while `busy`=1 is ignored, including MTHI/MTLO. Execute is stalled, so no request is lost.
- `reset` at any time, including mid-RUN:
  - State goes to IDLE; `hi`=0, `lo`=0, `busy`=0, `dbz`=0, counter=0.
  - The partial result is discarded.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `dbz`=0.
- MTHI/MTLO: accepted at edge E0; the new value is visible on `hi`/`lo` after E0.
- DIV/DIVU request accepted at edge E0:
  - PREP occupies the cycle after E0.
  - RUN spans E1..E33 (32 iterations).
  - FIX writes at E34.
  - `busy`=1 from E0 to E34, i.e. 34 cycles.
  - `hi`/`lo` update and `busy` falls at the same edge, so a request can be accepted in the cycle right after.
- Divide by zero: `busy`=1 for exactly one cycle (PREP). `dbz`=1 for the one cycle after E1, coincident with `busy`=0.
- Decode is registered; `busy` is a registered output (state != IDLE) with no combinational path from `op_valid`.

## Structure
- Shared package `mips_cpu_hilo_pkg`:
  - `hilo_op_t` (op encoding above);
  - `hilo_state_t` (IDLE/PREP/RUN/FIX);
  - `DIV_ITERS`=32.
  - This package is shared with the execute-stage decoder.
- One sub-module: `mips_cpu_divcore`, the unsigned restoring core.
  - Inputs: clk, reset, `start` pulse, two 32-bit magnitudes.
  - Outputs: q and r (32 bits each) plus a one-cycle `done` pulse; `done` is cleared on every start.
  - The parent owns sign handling, divide-by-zero detection and HI/LO.

## Test plan
- DIVU rs=100, rt=7 -> `busy` high exactly 34 cycles, then LO=14, HI=2; `dbz` stays 0.
- DIV rs=0xFFFFFFF9 (−7), rt=2 -> LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). Also 7/−2 -> LO=0xFFFFFFFD, HI=1.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 0xFFFFFFFF/0x80000000 -> LO=1, HI=0x7FFFFFFF.
- MTHI 0xAAAA5555, MTLO 0x1234, then DIVU 5/0 -> `dbz` one-cycle pulse, `busy` high 1 cycle, HI/LO unchanged.
- Start DIVU 1000/3, issue MTLO 0xDEAD with `op_valid` on cycle 5 -> MTLO ignored; final LO=333, HI=1.
- Start DIV, assert `reset` on RUN cycle 10 -> next cycle `busy`=0, HI=LO=0. A following DIVU 9/3 -> LO=3, HI=0 after 34 cycles.
